mem_stage_ld: RTL and testbench
===============================

Name: mem_stage_ld

Overview:
- Parametrised MEM pipeline stage for the 5-stage core; replaces the fixed-width, single-cycle-load MEM stage.
- Registers the EX->MEM bundle with stall and bubble control, and supports variable-latency data SRAM responses through a wait FSM.
- Performs byte, half, word and (64-bit only) dword load extraction with sign or zero extension.
- Drives the WB bundle and the ID forwarding path; raises a stall request while load data is outstanding.

Parameters:
DATA_W, 32, datapath and SRAM data width; legal values are 32 and 64.
PC_W, 32, PC width.
RA_W, 5, register-file address width.
LANE_W, log2(DATA_W/8), derived; byte-lane select width; not user-set.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard stage contents; cancel any pending load
stall_hold  in  1  stage register must not accept new input
stall_next  in  1  WB stage is stalled
ex_valid  in  1  EX bundle valid
ex_pc  in  PC_W  instruction PC
ex_load  in  1  1 = result is load data; 0 = ex_result
ex_ld_size  in  2  0 byte, 1 half, 2 word, 3 dword
ex_ld_signed  in  1  1 = sign-extend; 0 = zero-extend
ex_rf_we  in  1  register write enable
ex_rf_waddr  in  RA_W  destination register
ex_result  in  DATA_W  ALU result / load address
mem_rvalid  in  1  SRAM read data valid this cycle
mem_rdata  in  DATA_W  SRAM read data
wb_valid  out  1  WB bundle valid
wb_pc  out  PC_W  PC to WB
wb_rf_we  out  1  write enable to WB; gated by wb_valid
wb_rf_waddr  out  RA_W  destination to WB
wb_rf_wdata  out  DATA_W  write data to WB
fwd_we  out  1  forwarding write enable (= wb_rf_we)
fwd_waddr  out  RA_W  forwarding address
fwd_wdata  out  DATA_W  forwarding data
fwd_pending  out  1  a load is in the stage and its data is not yet available; ID must not consume fwd_wdata
stallreq  out  1  stall request to the stall controller

Behaviour:
- Stage register update, in priority order:
  - rst or flush: register cleared to a bubble (all fields 0).
  - stall_hold=1 and stall_next=0: bubble inserted.
  - stall_hold=0: load the EX inputs.
  - Otherwise: hold.
- FSM states: IDLE, WAIT, DONE, DROP. Reset state IDLE.
- A load is "in stage" when the registered valid=1 and ex_load=1.
- IDLE: when a load is in stage, a same-cycle mem_rvalid makes the data usable directly and captures it into the buffer.
  - If the register does not advance that cycle, go to DONE.
  - Without mem_rvalid, go to WAIT.
- WAIT: mem_rvalid captures mem_rdata into the data buffer and moves to DONE, or to IDLE if the register advances that cycle.
- DONE: the buffer supplies the load data. Go to IDLE when the register loads new content or a bubble.
- DROP: entered when flush is asserted in WAIT, or in IDLE with an uncompleted load. The first subsequent mem_rvalid is discarded.
  - Then go to WAIT if a load is now in stage, else IDLE.
  - A further flush while in DROP stays in DROP.
- stallreq = load in stage AND data not yet available (WAIT, DROP, or IDLE without mem_rvalid). It is combinational and deasserts in the same cycle as the mem_rvalid that completes the load.
- fwd_pending has the same timing as stallreq.
- Load data source: live mem_rdata in the response cycle, otherwise the buffer.
- Extraction uses lane = ex_result[LANE_W-1:0]:
  - byte: lane selects the 8-bit field.
  - half: lane[LANE_W-1:1] selects the 16-bit field; lane[0] is ignored (no misalignment trap).
  - word: the 32-bit field is selected by lane bit 2 when DATA_W=64; full word when DATA_W=32.
  - dword: full data when DATA_W=64; treated as word when DATA_W=32.
- Extension to DATA_W: sign-extend if ex_ld_signed, else zero-extend.
- wb_rf_wdata = extracted load data if ex_load, else ex_result.
- mem_rvalid in IDLE with no load in stage is ignored.
- Reset: every output 0; data buffer 0.

Test Plan:
- ALU op: ex_valid=1, ex_load=0, rf_we=1, waddr=5, result=0x1234 -> next cycle wb_rf_wdata=0x1234, fwd_we=1, fwd_waddr=5, stallreq=0.
- Signed byte load, addr=0x103, rvalid in the entry cycle with rdata=0x80FF_0011 -> wdata=0xFFFF_FF80, stallreq=0 throughout.
- Unsigned half load, addr=0x2, rvalid 3 cycles late with rdata=0xBEEF_0000 -> stallreq=1 and fwd_pending=1 for 3 cycles, then wdata=0x0000_BEEF.
- Load completes while stall_hold=1 and stall_next=1 for 2 extra cycles -> FSM reaches DONE, wdata stays valid from the buffer, no new input is latched.
- Flush during WAIT, then a new word load enters; first rvalid (stale data 0xDEAD_DEAD) is dropped, second rvalid returns 0x0000_0042 -> wdata=0x42, stale value never appears on the outputs.
- DATA_W=64: dword load returning 0x0123_4567_89AB_CDEF -> full value; signed word at addr=0x4 -> 0x0000_0000_0123_4567; bubble insertion (hold=1, next=0) -> wb_valid=0 and wb_rf_we=0.

Source files
------------

// File: rtl/mem_stage_ld_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ld_if
//  Purpose  : Bundle interface of the MEM stage. Carries the EX->MEM bundle,
//             the data SRAM read response, the WB bundle and the ID
//             forwarding path.
//  Modports : slave  - the MEM stage (consumes EX/SRAM, drives WB/forwarding)
//             master - the environment around the stage
//  Revision : 1.0  initial release
// ============================================================================
interface mem_stage_ld_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
);
    // EX -> MEM bundle
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic              ex_load;
    logic [1:0]        ex_ld_size;
    logic              ex_ld_signed;
    logic              ex_rf_we;
    logic [RA_W-1:0]   ex_rf_waddr;
    logic [DATA_W-1:0] ex_result;
    // data SRAM read response
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    // MEM -> WB bundle
    logic              wb_valid;
    logic [PC_W-1:0]   wb_pc;
    logic              wb_rf_we;
    logic [RA_W-1:0]   wb_rf_waddr;
    logic [DATA_W-1:0] wb_rf_wdata;
    // forwarding path to ID
    logic              fwd_we;
    logic [RA_W-1:0]   fwd_waddr;
    logic [DATA_W-1:0] fwd_wdata;
    logic              fwd_pending;

    modport slave (
        input  ex_valid, ex_pc, ex_load, ex_ld_size, ex_ld_signed,
               ex_rf_we, ex_rf_waddr, ex_result, mem_rvalid, mem_rdata,
        output wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
               fwd_we, fwd_waddr, fwd_wdata, fwd_pending
    );

    modport master (
        output ex_valid, ex_pc, ex_load, ex_ld_size, ex_ld_signed,
               ex_rf_we, ex_rf_waddr, ex_result, mem_rvalid, mem_rdata,
        input  wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
               fwd_we, fwd_waddr, fwd_wdata, fwd_pending
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ld.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ld
//  Purpose  : Parametrised MEM pipeline stage. Registers the EX bundle with
//             stall/bubble control, waits for variable-latency SRAM load
//             data, extracts byte/half/word/dword with sign or zero
//             extension, and drives the WB bundle and ID forwarding path.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             flush_i          - discard stage contents, cancel pending load
//             stall_hold_i     - stage register must not accept new input
//             stall_next_i     - WB stage is stalled
//             bus (slave)      - EX bundle, SRAM response, WB bundle, fwd
//             stallreq_o       - load data outstanding, stall the pipe
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_ld #(
    parameter int DATA_W = 32,   // 32 or 64
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 stall_hold_i,
    input  logic                 stall_next_i,
    mem_stage_ld_if.slave        bus,
    output logic                 stallreq_o
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic              load;
        logic [1:0]        size;
        logic              sgn;
        logic              we;
        logic [RA_W-1:0]   waddr;
        logic [DATA_W-1:0] result;
    } stage_t;

    stage_t            stage_q, stage_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] ldbuf_q;

    logic              w_adv;        // register takes new content or a bubble
    logic              w_ld_in;      // load in stage
    logic              w_data_avail;
    logic              w_use_live;
    logic              w_capture;
    logic              w_pending;

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = '0;
        end else if (stall_hold_i && !stall_next_i) begin
            stage_d = '0;
        end else if (!stall_hold_i) begin
            stage_d.valid  = bus.ex_valid;
            stage_d.pc     = bus.ex_pc;
            stage_d.load   = bus.ex_load;
            stage_d.size   = bus.ex_ld_size;
            stage_d.sgn    = bus.ex_ld_signed;
            stage_d.we     = bus.ex_rf_we;
            stage_d.waddr  = bus.ex_rf_waddr;
            stage_d.result = bus.ex_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign w_adv   = flush_i | ~(stall_hold_i & stall_next_i);
    assign w_ld_in = stage_q.valid & stage_q.load;

    // ------------------------------------------------------------------
    // Load-wait FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Load-wait FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_ld_in) begin
                    if (bus.mem_rvalid) begin
                        state_d = w_adv ? S_IDLE : S_DONE;
                    end else if (flush_i) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response arriving with a flush still belongs to the
                // flushed load, so it retires it rather than arming a drop.
                if (bus.mem_rvalid) begin
                    state_d = w_adv ? S_IDLE : S_DONE;
                end else if (flush_i) begin
                    state_d = S_DROP;
                end
            end
            S_DONE: begin
                if (w_adv) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (flush_i) begin
                    state_d = S_DROP;
                end else if (bus.mem_rvalid) begin
                    // the response of the cancelled load is swallowed here;
                    // a load already waiting in the register still needs one
                    state_d = (w_ld_in && !w_adv) ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load-wait FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_data_avail = 1'b0;
        w_use_live   = 1'b0;
        w_capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_ld_in && bus.mem_rvalid) begin
                    w_data_avail = 1'b1;
                    w_use_live   = 1'b1;
                    w_capture    = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_data_avail = 1'b1;
                    w_use_live   = 1'b1;
                    w_capture    = 1'b1;
                end
            end
            S_DONE:  w_data_avail = 1'b1;
            default: w_data_avail = 1'b0;
        endcase
    end

    assign w_pending = w_ld_in & ~w_data_avail;

    always_ff @(posedge clk) begin
        if (rst) begin
            ldbuf_q <= '0;
        end else if (w_capture) begin
            ldbuf_q <= bus.mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Lane extraction and extension
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] w_lane;
    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_byte_sh;
    logic [DATA_W-1:0] w_half_sh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_word_ext;
    logic [DATA_W-1:0] w_dword;
    logic [DATA_W-1:0] w_ld_data;

    assign w_lane    = stage_q.result[LANE_W-1:0];
    assign w_raw     = w_use_live ? bus.mem_rdata : ldbuf_q;
    assign w_byte_sh = w_raw >> {w_lane, 3'b000};
    // half-word alignment ignores lane bit 0; no misalignment trap
    assign w_half_sh = w_raw >> {w_lane[LANE_W-1:1], 4'b0000};
    assign w_byte    = w_byte_sh[7:0];
    assign w_half    = w_half_sh[15:0];

    generate
        if (DATA_W == 64) begin : g_dw64
            logic [31:0] w_word;
            assign w_word     = w_lane[2] ? w_raw[63:32] : w_raw[31:0];
            assign w_word_ext = {{(DATA_W-32){stage_q.sgn & w_word[31]}}, w_word};
            assign w_dword    = w_raw;
        end else begin : g_dw32
            // word fills the datapath; dword degrades to word
            assign w_word_ext = w_raw;
            assign w_dword    = w_raw;
        end
    endgenerate

    always_comb begin
        w_ld_data = '0;
        case (stage_q.size)
            2'd0: w_ld_data = {{(DATA_W-8){stage_q.sgn & w_byte[7]}}, w_byte};
            2'd1: w_ld_data = {{(DATA_W-16){stage_q.sgn & w_half[15]}}, w_half};
            2'd2: w_ld_data = w_word_ext;
            default: w_ld_data = w_dword;
        endcase
    end

    // ------------------------------------------------------------------
    // WB bundle and forwarding
    // ------------------------------------------------------------------
    logic              w_rf_we;
    logic [DATA_W-1:0] w_wdata;

    assign w_rf_we = stage_q.valid & stage_q.we;
    assign w_wdata = stage_q.load ? w_ld_data : stage_q.result;

    assign bus.wb_valid    = stage_q.valid;
    assign bus.wb_pc       = stage_q.pc;
    assign bus.wb_rf_we    = w_rf_we;
    assign bus.wb_rf_waddr = stage_q.waddr;
    assign bus.wb_rf_wdata = w_wdata;
    assign bus.fwd_we      = w_rf_we;
    assign bus.fwd_waddr   = stage_q.waddr;
    assign bus.fwd_wdata   = w_wdata;
    assign bus.fwd_pending = w_pending;
    assign stallreq_o      = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ld.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_ld
//  Purpose  : Self-checking bench for mem_stage_ld. A 32-bit and a 64-bit
//             instance receive the same directed stimulus; a behavioural
//             model predicts both every cycle, and literal expectations pin
//             the model on the directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_ld;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush = 0, hold = 0, nxt = 0;
    logic        ex_valid = 0, ex_load = 0, ex_sgn = 0, ex_we = 0;
    logic [1:0]  ex_size = 0;
    logic [4:0]  ex_waddr = 0;
    logic [31:0] ex_pc = 32'h1000;
    logic [63:0] ex_result = 0;
    logic        rvalid = 0;
    logic [63:0] rdata = 0;
    logic        stallreq32, stallreq64;

    mem_stage_ld_if #(.DATA_W(32), .PC_W(32), .RA_W(5)) if32 ();
    mem_stage_ld_if #(.DATA_W(64), .PC_W(32), .RA_W(5)) if64 ();

    assign if32.ex_valid     = ex_valid;
    assign if32.ex_pc        = ex_pc;
    assign if32.ex_load      = ex_load;
    assign if32.ex_ld_size   = ex_size;
    assign if32.ex_ld_signed = ex_sgn;
    assign if32.ex_rf_we     = ex_we;
    assign if32.ex_rf_waddr  = ex_waddr;
    assign if32.ex_result    = ex_result[31:0];
    assign if32.mem_rvalid   = rvalid;
    assign if32.mem_rdata    = rdata[31:0];

    assign if64.ex_valid     = ex_valid;
    assign if64.ex_pc        = ex_pc;
    assign if64.ex_load      = ex_load;
    assign if64.ex_ld_size   = ex_size;
    assign if64.ex_ld_signed = ex_sgn;
    assign if64.ex_rf_we     = ex_we;
    assign if64.ex_rf_waddr  = ex_waddr;
    assign if64.ex_result    = ex_result;
    assign if64.mem_rvalid   = rvalid;
    assign if64.mem_rdata    = rdata;

    mem_stage_ld #(.DATA_W(32), .PC_W(32), .RA_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_hold_i(hold),
        .stall_next_i(nxt), .bus(if32.slave), .stallreq_o(stallreq32)
    );

    mem_stage_ld #(.DATA_W(64), .PC_W(32), .RA_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_hold_i(hold),
        .stall_next_i(nxt), .bus(if64.slave), .stallreq_o(stallreq64)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: register contents, whether this load's data has
    // arrived, and whether a cancelled load's response is still due.
    // ------------------------------------------------------------------
    logic        model_on = 0;
    logic        m_valid = 0, m_load = 0, m_sgn = 0, m_we = 0;
    logic [1:0]  m_size = 0;
    logic [4:0]  m_waddr = 0;
    logic [31:0] m_pc = 0;
    logic [63:0] m_result = 0;
    logic        m_have = 0;
    logic        m_drop = 0;
    logic [63:0] m_data = 0;

    function automatic logic [63:0] exp_ld(input logic [63:0] raw, input logic [1:0] size,
                                           input logic sgn, input logic [63:0] addr, input int dw);
        logic [63:0] r, v, mask;
        int nb, lane, bits, off;
        nb   = dw / 8;
        lane = int'(addr[2:0]) % nb;
        r    = (dw == 32) ? {32'b0, raw[31:0]} : raw;
        case (size)
            2'd0:    begin bits = 8;  off = lane * 8;         end
            2'd1:    begin bits = 16; off = (lane / 2) * 16;  end
            2'd2:    begin bits = 32; off = (lane / 4) * 32;  end
            default: begin bits = dw; off = 0;                end
        endcase
        v = r >> off;
        if (bits < 64) begin
            mask = (64'd1 << bits) - 64'd1;
            v = v & mask;
            if (sgn && v[bits-1]) v = v | ~mask;
        end
        if (dw == 32) v = {32'b0, v[31:0]};
        return v;
    endfunction

    task automatic cmp_dut(input string tag, input int dw, input logic v, input logic [31:0] pc,
                           input logic we, input logic [4:0] wa, input logic [63:0] wd,
                           input logic fwe, input logic [4:0] fwa, input logic [63:0] fwd,
                           input logic fp, input logic sr, input logic pend, input logic [63:0] raw);
        logic [63:0] ew;
        chk({tag, ".wb_valid"},    {63'b0, v},   {63'b0, m_valid});
        chk({tag, ".wb_pc"},       {32'b0, pc},  {32'b0, m_pc});
        chk({tag, ".wb_rf_we"},    {63'b0, we},  {63'b0, m_valid & m_we});
        chk({tag, ".wb_rf_waddr"}, {59'b0, wa},  {59'b0, m_waddr});
        chk({tag, ".fwd_we"},      {63'b0, fwe}, {63'b0, m_valid & m_we});
        chk({tag, ".fwd_waddr"},   {59'b0, fwa}, {59'b0, m_waddr});
        chk({tag, ".stallreq"},    {63'b0, sr},  {63'b0, pend});
        chk({tag, ".fwd_pending"}, {63'b0, fp},  {63'b0, pend});
        if (!pend) begin
            ew = m_load ? exp_ld(raw, m_size, m_sgn, m_result, dw)
                        : ((dw == 32) ? {32'b0, m_result[31:0]} : m_result);
            chk({tag, ".wb_rf_wdata"}, wd,  ew);
            chk({tag, ".fwd_wdata"},   fwd, ew);
        end
    endtask

    always @(negedge clk) begin : p_cmp
        logic        lis, live, pend, adv;
        logic [63:0] raw;
        if (model_on) begin
            lis  = m_valid & m_load;
            live = lis & rvalid & !m_have & !m_drop;
            pend = lis & !(m_have | live);
            raw  = m_have ? m_data : rdata;

            cmp_dut("d32", 32, if32.wb_valid, if32.wb_pc, if32.wb_rf_we, if32.wb_rf_waddr,
                    {32'b0, if32.wb_rf_wdata}, if32.fwd_we, if32.fwd_waddr,
                    {32'b0, if32.fwd_wdata}, if32.fwd_pending, stallreq32, pend, raw);
            cmp_dut("d64", 64, if64.wb_valid, if64.wb_pc, if64.wb_rf_we, if64.wb_rf_waddr,
                    if64.wb_rf_wdata, if64.fwd_we, if64.fwd_waddr,
                    if64.fwd_wdata, if64.fwd_pending, stallreq64, pend, raw);

            // advance the model with the inputs the next clock edge will see
            if (rvalid) begin
                if (m_drop) m_drop = 1'b0;
                else if (lis && !m_have) begin
                    m_data = rdata;
                    m_have = 1'b1;
                end
            end
            if (flush && pend) m_drop = 1'b1;
            adv = rst | flush | !(hold & nxt);
            if (adv) m_have = 1'b0;

            if (rst || flush || (hold && !nxt)) begin
                {m_valid, m_pc, m_load, m_size, m_sgn, m_we, m_waddr, m_result} = '0;
            end else if (!hold) begin
                m_valid = ex_valid;  m_pc = ex_pc;     m_load = ex_load;  m_size = ex_size;
                m_sgn = ex_sgn;      m_we = ex_we;     m_waddr = ex_waddr; m_result = ex_result;
            end
            if (rst) begin
                m_have = 1'b0;
                m_drop = 1'b0;
                m_data = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic ld, input logic [1:0] sz, input logic sg,
                          input logic we, input logic [4:0] wa, input logic [63:0] res);
        ex_valid = v;  ex_load = ld;  ex_size = sz;  ex_sgn = sg;
        ex_we = we;    ex_waddr = wa; ex_result = res;
        ex_pc = ex_pc + 32'd4;
    endtask

    task automatic ex_clr();
        ex_valid = 0; ex_load = 0; ex_size = 0; ex_sgn = 0;
        ex_we = 0;    ex_waddr = 0; ex_result = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        model_on = 1;
        @(negedge clk);
        chk("rst_wb_valid",  {63'b0, if64.wb_valid}, 64'd0);
        chk("rst_stallreq",  {63'b0, stallreq32},    64'd0);
        chk("rst_wdata64",   if64.wb_rf_wdata,       64'd0);

        // ALU result passes through
        cyc(); rst = 0; ex_set(1, 0, 2'd0, 0, 1, 5'd5, 64'h1234);
        cyc(); ex_clr();
        @(negedge clk);
        chk("alu_wdata32",  {32'b0, if32.wb_rf_wdata}, 64'h1234);
        chk("alu_fwd_we",   {63'b0, if32.fwd_we},      64'd1);
        chk("alu_fwd_wa",   {59'b0, if32.fwd_waddr},   64'd5);
        chk("alu_stallreq", {63'b0, stallreq32},       64'd0);

        // signed byte, data in the entry cycle
        cyc(); ex_set(1, 1, 2'd0, 1, 1, 5'd7, 64'h103);
        cyc(); ex_clr(); rvalid = 1; rdata = 64'h80FF_0011;
        @(negedge clk);
        chk("lb_wdata32",   {32'b0, if32.wb_rf_wdata}, 64'hFFFF_FF80);
        chk("lb_wdata64",   if64.wb_rf_wdata,          64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_stallreq",  {63'b0, stallreq32},       64'd0);
        cyc(); rvalid = 0;

        // unsigned half, data three cycles late
        ex_set(1, 1, 2'd1, 0, 1, 5'd9, 64'h2);
        cyc(); ex_clr(); hold = 1; nxt = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lh_wait_stallreq", {63'b0, stallreq32},       64'd1);
            chk("lh_wait_pending",  {63'b0, if64.fwd_pending}, 64'd1);
            cyc();
        end
        rvalid = 1; rdata = 64'hBEEF_0000; hold = 0; nxt = 0;
        @(negedge clk);
        chk("lh_done_stallreq", {63'b0, stallreq32},       64'd0);
        chk("lh_wdata32",       {32'b0, if32.wb_rf_wdata}, 64'h0000_BEEF);
        chk("lh_wdata64",       if64.wb_rf_wdata,          64'h0000_BEEF);
        cyc(); rvalid = 0;

        // load completes while the pipe is held; new input must not latch
        ex_set(1, 1, 2'd2, 0, 1, 5'd11, 64'h8);
        cyc(); rvalid = 1; rdata = 64'h1122_3344_5566_7788; hold = 1; nxt = 1;
        ex_set(1, 0, 2'd0, 0, 1, 5'd3, 64'h999);
        @(negedge clk);
        chk("lw_wdata32", {32'b0, if32.wb_rf_wdata}, 64'h5566_7788);
        cyc(); rvalid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("held_wdata32", {32'b0, if32.wb_rf_wdata}, 64'h5566_7788);
            chk("held_wdata64", if64.wb_rf_wdata,          64'h5566_7788);
            chk("held_waddr",   {59'b0, if32.wb_rf_waddr}, 64'd11);
            cyc();
        end
        hold = 0; nxt = 0; ex_clr();
        cyc();

        // flush while waiting; stale response must be swallowed
        ex_set(1, 1, 2'd2, 0, 1, 5'd12, 64'h0);
        cyc(); ex_clr(); hold = 1; nxt = 1;
        @(negedge clk);
        chk("fl_a_stallreq", {63'b0, stallreq32}, 64'd1);
        cyc(); flush = 1;
        cyc(); flush = 0; hold = 0; nxt = 0; ex_set(1, 1, 2'd2, 0, 1, 5'd13, 64'h20);
        @(negedge clk);
        chk("fl_empty_valid", {63'b0, if32.wb_valid}, 64'd0);
        cyc(); ex_clr(); hold = 1; nxt = 1; rvalid = 1; rdata = 64'hDEAD_DEAD;
        @(negedge clk);
        chk("fl_stale_stallreq", {63'b0, stallreq64},       64'd1);
        chk("fl_stale_pending",  {63'b0, if32.fwd_pending}, 64'd1);
        cyc(); rdata = 64'h42; hold = 0; nxt = 0;
        @(negedge clk);
        chk("fl_wdata32",   {32'b0, if32.wb_rf_wdata}, 64'h42);
        chk("fl_wdata64",   if64.wb_rf_wdata,          64'h42);
        chk("fl_stallreq",  {63'b0, stallreq32},       64'd0);
        chk("fl_waddr",     {59'b0, if64.wb_rf_waddr}, 64'd13);
        cyc(); rvalid = 0;

        // dword, then signed word in upper half, then bubble insertion
        ex_set(1, 1, 2'd3, 0, 1, 5'd14, 64'h10);
        cyc(); ex_set(1, 1, 2'd2, 1, 1, 5'd15, 64'h4); rvalid = 1; rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        chk("ld_wdata64", if64.wb_rf_wdata,          64'h0123_4567_89AB_CDEF);
        chk("ld_wdata32", {32'b0, if32.wb_rf_wdata}, 64'h89AB_CDEF);
        cyc(); ex_set(1, 0, 2'd0, 0, 1, 5'd16, 64'h77);
        @(negedge clk);
        chk("lw_s_wdata64", if64.wb_rf_wdata,          64'h0000_0000_0123_4567);
        chk("lw_s_wdata32", {32'b0, if32.wb_rf_wdata}, 64'h89AB_CDEF);
        cyc(); rvalid = 0; ex_clr(); hold = 1; nxt = 0;
        @(negedge clk);
        chk("alu2_wdata64", if64.wb_rf_wdata, 64'h77);
        cyc(); hold = 0;
        @(negedge clk);
        chk("bub_valid64", {63'b0, if64.wb_valid}, 64'd0);
        chk("bub_we64",    {63'b0, if64.wb_rf_we}, 64'd0);
        chk("bub_valid32", {63'b0, if32.wb_valid}, 64'd0);
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
